mario_left_right_mover: RTL and testbench
=========================================

Name: mario_left_right_mover

Overview:
- Horizontal counterpart of the vertical mover. Produces Mario's x position from the left/right buttons, the tile background map and Mario's current y.
- Walk/run speed ramp, direction tracking, collision against blocks/ground/border tiles, and screen clamping.
- Sits beside the vertical mover on movement_clock. Its mario_x feeds the vertical mover and the renderer.

Parameters:
- BDR, 0, tile code for border
- SKY, 1, tile code for sky
- BLK, 2, tile code for block
- GND, 3, tile code for ground
- MARIO_WIDTH, 42, Mario sprite width/height in pixels
- SCREEN_WIDTH, 640, screen width in pixels
- BLOCK_WIDTH, 40, tile edge in pixels
- START_X, 80, x after reset
- WALK_DIV, 4, movement_clock ticks per pixel while walking
- RUN_AFTER, 16, pixels walked before switching to run (1 px/tick)

Ports:
- movement_clock  input  1  movement tick clock
- reset  input  1  asynchronous, active-low
- move_left  input  1  left button, level
- move_right  input  1  right button, level
- background  input  12x17x8  tile map [row 0..11][col 0..16], byte tile codes
- mario_y  input  32 signed  Mario top y (pixels)
- mario_x  output  32 signed  Mario left x (pixels)
- facing_left  output  1  1 = last requested direction was left
- moving  output  1  1 while in WALK or RUN
- leds  output  10  active-low one-hot state indicator

Behaviour:
- Clock and reset: reset is asynchronous, active-low; clock is movement_clock. All outputs are registered.
- Reset values: mario_x=START_X, facing_left=0, moving=0, leds=10'b1111111110, state=RESET, div counter=0, walked counter=0.
- Direction request dir: left if move_left&&!move_right; right if move_right&&!move_left; none otherwise. Both pressed counts as none.
- Collision tiles:
  - rows rt=mario_y/BLOCK_WIDTH, rb=(mario_y+MARIO_WIDTH-1)/BLOCK_WIDTH
  - left column cl=(mario_x-1)/BLOCK_WIDTH; right column cr=(mario_x+MARIO_WIDTH)/BLOCK_WIDTH
  - Indices are clamped to 0..11 rows and 0..16 cols.
  - blocked_left when any of [rt][cl],[rb][cl] is BDR, BLK or GND, or mario_x<=0.
  - blocked_right when any of [rt][cr],[rb][cr] is BDR, BLK or GND, or mario_x>=SCREEN_WIDTH-MARIO_WIDTH.
- States (one-hot enum; leds bit n low in state n):
  - RESET(bit0) -> IDLE on the next edge.
  - IDLE(bit1):
    - dir none, or dir blocked -> IDLE.
    - Otherwise -> WALK, latch facing_left=(dir==left), clear div and walked counters.
    - facing_left also updates in IDLE when dir is blocked.
  - WALK(bit2):
    - dir none, or dir != latched direction -> IDLE. This gives a one-cycle stop on reversal; no x change that edge.
    - Blocked in the latched direction -> IDLE, no x change.
    - Otherwise div++. When div==WALK_DIV-1: x moves ±1, div=0, walked++.
    - When walked reaches RUN_AFTER on a move -> RUN.
  - RUN(bit3):
    - Same exits as WALK.
    - Otherwise x moves ±1 every edge.
- moving=1 exactly in WALK/RUN.
- Arithmetic: x is updated only by ±1 per edge and never leaves [0, SCREEN_WIDTH-MARIO_WIDTH]. There is no wrap-around.
- Latency: direction sampled at edge k (IDLE->WALK). The first pixel move occurs at edge k+WALK_DIV.
- Reset asserted mid-move: immediate return to reset values regardless of state. After release, the first edge goes to IDLE.
- Background or mario_y changing mid-move: collision is re-evaluated every edge with current inputs.

Test Plan:
- Reset then hold move_right with an all-SKY row band -> state WALK after 1 edge, mario_x=81 at edge 1+4. After 16 walked pixels (x=96) enter RUN, then x increments by 1 per edge.
- Hold move_left from x=80, y=360 with a BLK tile at [9][1] and [10][1] -> walks until x=80 (cl=(80-1)/40=1 is blocked) -> IDLE, facing_left=1, x stays 80.
- Running right, switch to move_left -> one edge in IDLE with x unchanged, then WALK left. The first left pixel arrives WALK_DIV edges later. facing_left goes 0->1.
- Press both buttons in IDLE and in RUN -> IDLE, moving=0, x frozen.
- Run right with an all-SKY map -> x saturates at 598 (640-42), state IDLE, no overshoot.
- Assert reset while in RUN at x=300 -> mario_x=80, leds=1111111110 asynchronously. The first edge after release gives leds=1111111101 (IDLE).

Source files
------------

// File: rtl/mario_left_right_mover.sv
// mario_left_right_mover: horizontal position of Mario from the left/right buttons,
// with a walk-to-run speed ramp, tile collision and screen clamping.
`default_nettype none

module mario_left_right_mover #(
    parameter logic [7:0] BDR          = 8'd0,
    parameter logic [7:0] SKY          = 8'd1,
    parameter logic [7:0] BLK          = 8'd2,
    parameter logic [7:0] GND          = 8'd3,
    parameter int         MARIO_WIDTH  = 42,
    parameter int         SCREEN_WIDTH = 640,
    parameter int         BLOCK_WIDTH  = 40,
    parameter int         START_X      = 80,
    parameter int         WALK_DIV     = 4,
    parameter int         RUN_AFTER    = 16
) (
    input  logic                          movement_clock,
    input  logic                          reset,
    input  logic                          move_left,
    input  logic                          move_right,
    input  logic [11:0][16:0][7:0]        background,
    input  logic signed [31:0]            mario_y,
    output logic signed [31:0]            mario_x,
    output logic                          facing_left,
    output logic                          moving,
    output logic [9:0]                    leds
);

    localparam int DIV_W    = (WALK_DIV > 1) ? $clog2(WALK_DIV) : 1;
    localparam int WALKED_W = $clog2(RUN_AFTER + 1);
    localparam int X_MAX    = SCREEN_WIDTH - MARIO_WIDTH;

    typedef enum logic [3:0] {
        S_RESET = 4'b0001,
        S_IDLE  = 4'b0010,
        S_WALK  = 4'b0100,
        S_RUN   = 4'b1000
    } state_t;

    state_t                state_q, state_d;
    logic signed [31:0]    x_q, x_d;
    logic                  facing_q, facing_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [WALKED_W-1:0]   walked_q, walked_d;
    logic                  moving_q;
    logic [9:0]            leds_q;

    function automatic logic [3:0] row_idx(input logic signed [31:0] y);
        logic signed [31:0] r;
        r = y / BLOCK_WIDTH;
        if (r < 0)       return 4'd0;
        else if (r > 11) return 4'd11;
        else             return r[3:0];
    endfunction

    function automatic logic [4:0] col_idx(input logic signed [31:0] x);
        logic signed [31:0] c;
        c = x / BLOCK_WIDTH;
        if (c < 0)       return 5'd0;
        else if (c > 16) return 5'd16;
        else             return c[4:0];
    endfunction

    // A SKY tile is always passable, even if codes are overridden to overlap.
    function automatic logic is_solid(input logic [7:0] t);
        return (t != SKY) && ((t == BDR) || (t == BLK) || (t == GND));
    endfunction

    logic [3:0] rt, rb;
    logic [4:0] cl, cr;
    logic       blocked_left, blocked_right;
    logic       dir_left, dir_right;
    logic       dir_match, dir_blocked;
    logic signed [31:0] x_step;

    always_comb begin
        rt = row_idx(mario_y);
        rb = row_idx(mario_y + MARIO_WIDTH - 1);
        cl = col_idx(x_q - 1);
        cr = col_idx(x_q + MARIO_WIDTH);
        blocked_left  = is_solid(background[rt][cl]) || is_solid(background[rb][cl]) ||
                        (x_q <= 0);
        blocked_right = is_solid(background[rt][cr]) || is_solid(background[rb][cr]) ||
                        (x_q >= X_MAX);
        dir_left    = move_left && !move_right;
        dir_right   = move_right && !move_left;
        dir_match   = facing_q ? dir_left : dir_right;
        dir_blocked = facing_q ? blocked_left : blocked_right;
        x_step      = facing_q ? (x_q - 1) : (x_q + 1);
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        facing_d = facing_q;
        div_d    = div_q;
        walked_d = walked_q;
        case (state_q)
            S_RESET: state_d = S_IDLE;
            S_IDLE: begin
                if (dir_left) begin
                    facing_d = 1'b1;
                    if (!blocked_left) begin
                        state_d  = S_WALK;
                        div_d    = '0;
                        walked_d = '0;
                    end
                end else if (dir_right) begin
                    facing_d = 1'b0;
                    if (!blocked_right) begin
                        state_d  = S_WALK;
                        div_d    = '0;
                        walked_d = '0;
                    end
                end
            end
            S_WALK, S_RUN: begin
                // Reversal drops to IDLE for one edge; IDLE then relatches direction.
                if (!dir_match || dir_blocked) begin
                    state_d = S_IDLE;
                end else if (state_q == S_RUN) begin
                    x_d = x_step;
                end else if (div_q == DIV_W'(WALK_DIV - 1)) begin
                    x_d      = x_step;
                    div_d    = '0;
                    walked_d = walked_q + 1'b1;
                    if (walked_q + 1'b1 == WALKED_W'(RUN_AFTER)) begin
                        state_d = S_RUN;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge movement_clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_RESET;
            x_q      <= 32'(START_X);
            facing_q <= 1'b0;
            div_q    <= '0;
            walked_q <= '0;
            moving_q <= 1'b0;
            leds_q   <= 10'b1111111110;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            facing_q <= facing_d;
            div_q    <= div_d;
            walked_q <= walked_d;
            moving_q <= (state_d == S_WALK) || (state_d == S_RUN);
            leds_q   <= ~{6'b000000, state_d};
        end
    end

    assign mario_x     = x_q;
    assign facing_left = facing_q;
    assign moving      = moving_q;
    assign leds        = leds_q;

endmodule

`default_nettype wire

// File: tb/tb_mario_left_right_mover.sv
// Directed bench for mario_left_right_mover: reset, walk/run ramp, reversal, both buttons,
// screen clamp, asynchronous reset mid-run and tile collision on the left.
`default_nettype none

module tb_mario_left_right_mover;

    localparam logic [7:0] SKY = 8'd1;
    localparam logic [7:0] BLK = 8'd2;
    localparam logic [9:0] L_RESET = 10'b1111111110;
    localparam logic [9:0] L_IDLE  = 10'b1111111101;
    localparam logic [9:0] L_WALK  = 10'b1111111011;
    localparam logic [9:0] L_RUN   = 10'b1111110111;

    logic                   movement_clock;
    logic                   reset;
    logic                   move_left;
    logic                   move_right;
    logic [11:0][16:0][7:0] background;
    logic signed [31:0]     mario_y;
    logic signed [31:0]     mario_x;
    logic                   facing_left;
    logic                   moving;
    logic [9:0]             leds;

    int errors = 0;
    int checks = 0;

    mario_left_right_mover dut (
        .movement_clock (movement_clock),
        .reset          (reset),
        .move_left      (move_left),
        .move_right     (move_right),
        .background     (background),
        .mario_y        (mario_y),
        .mario_x        (mario_x),
        .facing_left    (facing_left),
        .moving         (moving),
        .leds           (leds)
    );

    initial begin
        movement_clock = 1'b0;
        forever #5 movement_clock = ~movement_clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge movement_clock);
        #1;
    endtask

    task automatic all_sky();
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 17; c++)
                background[r][c] = SKY;
    endtask

    task automatic chk_x(input string name, input int exp);
        checks++;
        if (mario_x !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: mario_x=%0d expected %0d", name, mario_x, exp);
        end
    endtask

    task automatic chk_leds(input string name, input logic [9:0] exp);
        checks++;
        if (leds !== exp) begin
            errors++;
            $display("FAIL %s: leds=%b expected %b", name, leds, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; move_left = 1'b0; move_right = 1'b0;
        mario_y = 32'sd360;
        all_sky();
        #12;
        chk_x("reset_x", 80);
        chk_leds("reset_leds", L_RESET);
        checks++;
        if (moving !== 1'b0 || facing_left !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: moving=%b facing=%b expected 0 0", moving, facing_left);
        end
        reset = 1'b1;
        tick(1);
        chk_leds("reset_first_edge_idle", L_IDLE);
    endtask

    task automatic test_walk_run();
        move_right = 1'b1;
        tick(1);
        chk_leds("walk_enter", L_WALK);
        checks++;
        if (moving !== 1'b1) begin
            errors++;
            $display("FAIL walk_moving: moving=%b expected 1", moving);
        end
        tick(3);
        chk_x("walk_no_px_yet", 80);
        tick(1);
        chk_x("walk_first_px", 81);
        tick(60);
        chk_x("walk_16px", 96);
        chk_leds("run_enter", L_RUN);
        tick(1);
        chk_x("run_step1", 97);
        tick(5);
        chk_x("run_step6", 102);
    endtask

    task automatic test_reverse();
        move_right = 1'b0; move_left = 1'b1;
        tick(1);
        chk_leds("rev_idle", L_IDLE);
        chk_x("rev_idle_x", 102);
        checks++;
        if (facing_left !== 1'b0) begin
            errors++;
            $display("FAIL rev_facing_hold: facing=%b expected 0", facing_left);
        end
        tick(1);
        chk_leds("rev_walk", L_WALK);
        checks++;
        if (facing_left !== 1'b1) begin
            errors++;
            $display("FAIL rev_facing_left: facing=%b expected 1", facing_left);
        end
        tick(3);
        chk_x("rev_no_px_yet", 102);
        tick(1);
        chk_x("rev_first_left_px", 101);
    endtask

    task automatic test_both_buttons();
        move_left = 1'b1; move_right = 1'b1;
        tick(1);
        chk_leds("both_walk_idle", L_IDLE);
        chk_x("both_walk_x", 101);
        tick(3);
        chk_leds("both_idle_stay", L_IDLE);
        chk_x("both_idle_x", 101);
    endtask

    task automatic test_saturate();
        move_left = 1'b0; move_right = 1'b1;
        tick(1);
        chk_leds("sat_walk", L_WALK);
        tick(64);
        chk_x("sat_run_x", 117);
        chk_leds("sat_run", L_RUN);
        move_left = 1'b1;
        tick(1);
        chk_leds("both_in_run_idle", L_IDLE);
        chk_x("both_in_run_x", 117);
        checks++;
        if (moving !== 1'b0) begin
            errors++;
            $display("FAIL both_in_run_moving: moving=%b expected 0", moving);
        end
        move_left = 1'b0;
        tick(65);
        chk_x("sat_run2_x", 133);
        tick(465);
        chk_x("sat_reach_edge", 598);
        tick(1);
        chk_leds("sat_idle", L_IDLE);
        chk_x("sat_no_overshoot", 598);
        tick(5);
        chk_x("sat_hold", 598);
        chk_leds("sat_hold_idle", L_IDLE);
    endtask

    task automatic test_reset_mid_run();
        move_right = 1'b0; move_left = 1'b0;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick(1);
        move_right = 1'b1;
        tick(65);
        chk_leds("mid_run_state", L_RUN);
        tick(204);
        chk_x("mid_run_x300", 300);
        reset = 1'b0;
        #1;
        chk_x("async_reset_x", 80);
        chk_leds("async_reset_leds", L_RESET);
        move_right = 1'b0;
        #1;
        reset = 1'b1;
        tick(1);
        chk_leds("after_release_idle", L_IDLE);
    endtask

    task automatic test_blocked_left();
        mario_y = 32'sd360;
        background[9][1]  = BLK;
        background[10][1] = BLK;
        move_left = 1'b1;
        tick(1);
        chk_leds("blk_left_idle", L_IDLE);
        chk_x("blk_left_x", 80);
        checks++;
        if (facing_left !== 1'b1) begin
            errors++;
            $display("FAIL blk_left_facing: facing=%b expected 1", facing_left);
        end
        tick(4);
        chk_x("blk_left_hold", 80);
        background[9][1]  = SKY;
        background[10][1] = SKY;
        tick(1);
        chk_leds("unblock_walk", L_WALK);
        tick(4);
        chk_x("unblock_px", 79);
        background[9][1] = BLK;
        tick(1);
        chk_leds("reblock_idle", L_IDLE);
        chk_x("reblock_x", 79);
        move_left = 1'b0;
    endtask

    initial begin
        test_reset();
        test_walk_run();
        test_reverse();
        test_both_buttons();
        test_saturate();
        test_reset_mid_run();
        test_blocked_left();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
